spatz_strbreq_merge_nway: RTL and testbench

SPATZ_STRBREQ_MERGE_NWAY -- requirements
Module: spatz_strbreq_merge_nway

---
 rtl/spatz_merge_pkg.sv | 27 ++
 rtl/spatz_merge_track_fifo.sv | 56 +++++
 rtl/spatz_strbreq_merge_nway.sv | 183 ++++++++++++++++++
 tb/tb_spatz_strbreq_merge_nway.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spatz_merge_pkg.sv
// Shared definitions for the N-way strobe request merger.
// Defaults describe the reference configuration of the merger.
package spatz_merge_pkg;

    localparam int unsigned DefNumPorts       = 8;
    localparam int unsigned DefDataWidth      = 32;
    localparam int unsigned DefAddrWidth      = 32;
    localparam int unsigned DefIdWidth        = 5;
    localparam int unsigned DefNumOutstanding = 16;

    localparam int unsigned StrbWidth = DefDataWidth / 8;
    localparam int unsigned PtrWidth  = $clog2(DefNumOutstanding);

    typedef struct packed {
        logic [DefNumPorts-1:0]                 mask;
        logic [DefNumPorts-1:0][DefIdWidth-1:0] ids;
    } track_entry_t;

    function automatic int unsigned strb_width(input int unsigned dw);
        return dw / 8;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/spatz_merge_track_fifo.sv
// Per-port tracking FIFO; a pop in the same cycle frees room for a push.
module spatz_merge_track_fifo
    import spatz_merge_pkg::*;
#(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = DefNumOutstanding
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = ptr_width(Depth);

    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [PtrW:0]    cnt_q, cnt_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (PtrW+1)'(Depth));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d = do_push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d = do_pop ? rptr_q + PtrW'(1) : rptr_q;
        cnt_d  = cnt_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/spatz_strbreq_merge_nway.sv
// Merges same-word VFU requests into one downstream request per leader
// and fans the single response back out to every merged member.
module spatz_strbreq_merge_nway
    import spatz_merge_pkg::*;
#(
    parameter int unsigned NumPorts       = DefNumPorts,
    parameter int unsigned DataWidth      = DefDataWidth,
    parameter int unsigned AddrWidth      = DefAddrWidth,
    parameter int unsigned IdWidth        = DefIdWidth,
    parameter int unsigned NumOutstanding = DefNumOutstanding,
    localparam int unsigned StrbW         = strb_width(DataWidth)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                merge_en_i,
    input  logic [NumPorts-1:0]                 in_q_valid_i,
    output logic [NumPorts-1:0]                 in_q_ready_o,
    input  logic [NumPorts-1:0][AddrWidth-1:0]  in_q_addr_i,
    input  logic [NumPorts-1:0]                 in_q_write_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]  in_q_data_i,
    input  logic [NumPorts-1:0][StrbW-1:0]      in_q_strb_i,
    input  logic [NumPorts-1:0][IdWidth-1:0]    in_q_id_i,
    output logic [NumPorts-1:0]                 out_q_valid_o,
    input  logic [NumPorts-1:0]                 out_q_ready_i,
    output logic [NumPorts-1:0][AddrWidth-1:0]  out_q_addr_o,
    output logic [NumPorts-1:0]                 out_q_write_o,
    output logic [NumPorts-1:0][DataWidth-1:0]  out_q_data_o,
    output logic [NumPorts-1:0][StrbW-1:0]      out_q_strb_o,
    output logic [NumPorts-1:0][IdWidth-1:0]    out_q_id_o,
    input  logic [NumPorts-1:0]                 out_p_valid_i,
    output logic [NumPorts-1:0]                 out_p_ready_o,
    input  logic [NumPorts-1:0][DataWidth-1:0]  out_p_data_i,
    output logic [NumPorts-1:0]                 in_p_valid_o,
    input  logic [NumPorts-1:0]                 in_p_ready_i,
    output logic [NumPorts-1:0][DataWidth-1:0]  in_p_data_o,
    output logic [NumPorts-1:0][IdWidth-1:0]    in_p_id_o,
    output logic [31:0]                         merge_cnt_o
);

    localparam int unsigned OffBits = $clog2(StrbW);
    localparam int unsigned LeadW   = $clog2(NumPorts);
    localparam int unsigned EntW    = NumPorts + NumPorts * IdWidth;

    logic [NumPorts-1:0]                             fol, claimed;
    logic [NumPorts-1:0]                             hs, fifo_full, fifo_empty;
    logic [NumPorts-1:0]                             pop, busy;
    logic [NumPorts-1:0][LeadW-1:0]                  lead;
    logic [NumPorts-1:0][StrbW-1:0]                  grp_strb;
    logic [NumPorts-1:0][DataWidth-1:0]              grp_data;
    logic [NumPorts-1:0][NumPorts-1:0]               grp_mask, head_mask;
    logic [NumPorts-1:0][NumPorts-1:0][IdWidth-1:0]  grp_ids, head_ids;
    logic [NumPorts-1:0][EntW-1:0]                   push_ent, head_ent;
    logic [31:0]                                     merge_cnt_q, merge_cnt_d;
    logic [31:0]                                     nfol;
    logic [32:0]                                     cnt_sum;

    function automatic logic word_eq(input logic [AddrWidth-1:0] a,
                                     input logic [AddrWidth-1:0] b);
        return ((a ^ b) >> OffBits) == '0;
    endfunction

    // Only the lowest matching open leader is tried; an overlap makes j stand alone.
    always_comb begin : group
        fol     = '0;
        claimed = '0;
        for (int j = 0; j < NumPorts; j++) begin
            lead[j]        = LeadW'(j);
            grp_strb[j]    = in_q_strb_i[j];
            grp_data[j]    = in_q_data_i[j];
            grp_mask[j]    = '0;
            grp_mask[j][j] = in_q_valid_i[j];
            grp_ids[j]     = '0;
            grp_ids[j][j]  = in_q_id_i[j];
        end
        for (int j = 1; j < NumPorts; j++) begin
            for (int i = 0; i < j; i++) begin
                if (merge_en_i && !claimed[j] && in_q_valid_i[i] &&
                    in_q_valid_i[j] && !fol[i] &&
                    (in_q_write_i[i] == in_q_write_i[j]) &&
                    word_eq(in_q_addr_i[i], in_q_addr_i[j])) begin
                    claimed[j] = 1'b1;
                    if (!in_q_write_i[j] ||
                        ((grp_strb[i] & in_q_strb_i[j]) == '0)) begin
                        fol[j]         = 1'b1;
                        lead[j]        = LeadW'(i);
                        grp_strb[i]    = grp_strb[i] | in_q_strb_i[j];
                        grp_mask[i][j] = 1'b1;
                        grp_ids[i][j]  = in_q_id_i[j];
                        for (int b = 0; b < StrbW; b++) begin
                            if (in_q_strb_i[j][b]) begin
                                grp_data[i][b*8 +: 8] = in_q_data_i[j][b*8 +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin : issue
        out_q_valid_o = '0;
        in_q_ready_o  = '0;
        for (int i = 0; i < NumPorts; i++) begin
            out_q_valid_o[i] = !rst_i && in_q_valid_i[i] && !fol[i] &&
                               (!fifo_full[i] || pop[i]);
        end
        hs = out_q_valid_o & out_q_ready_i;
        for (int m = 0; m < NumPorts; m++) begin
            in_q_ready_o[m] = in_q_valid_i[m] && hs[lead[m]];
        end
    end

    assign out_q_addr_o  = in_q_addr_i;
    assign out_q_write_o = in_q_write_i;
    assign out_q_id_o    = in_q_id_i;
    assign out_q_data_o  = grp_data;
    assign out_q_strb_o  = grp_strb;

    // A lower-index leader reserves its member ports before higher ones look.
    always_comb begin : resp
        busy          = '0;
        out_p_ready_o = '0;
        in_p_valid_o  = '0;
        in_p_data_o   = '0;
        in_p_id_o     = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (!rst_i && out_p_valid_i[i] && !fifo_empty[i] &&
                ((head_mask[i] & busy) == '0)) begin
                busy             = busy | head_mask[i];
                out_p_ready_o[i] = &(in_p_ready_i | ~head_mask[i]);
                for (int m = 0; m < NumPorts; m++) begin
                    if (head_mask[i][m]) begin
                        in_p_valid_o[m] = 1'b1;
                        in_p_data_o[m]  = out_p_data_i[i];
                        in_p_id_o[m]    = head_ids[i][m];
                    end
                end
            end
        end
        pop = out_p_ready_o;
    end

    for (genvar g = 0; g < NumPorts; g++) begin : g_track
        assign push_ent[g] = {grp_mask[g], grp_ids[g]};
        assign {head_mask[g], head_ids[g]} = head_ent[g];

        spatz_merge_track_fifo #(
            .Width (EntW),
            .Depth (NumOutstanding)
        ) i_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (hs[g]),
            .data_i  (push_ent[g]),
            .pop_i   (pop[g]),
            .data_o  (head_ent[g]),
            .full_o  (fifo_full[g]),
            .empty_o (fifo_empty[g])
        );
    end

    always_comb begin : count
        nfol = '0;
        for (int m = 0; m < NumPorts; m++) begin
            if (fol[m] && in_q_ready_o[m]) begin
                nfol = nfol + 32'd1;
            end
        end
        cnt_sum     = {1'b0, merge_cnt_q} + {1'b0, nfol};
        merge_cnt_d = cnt_sum[32] ? '1 : cnt_sum[31:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            merge_cnt_q <= '0;
        end else begin
            merge_cnt_q <= merge_cnt_d;
        end
    end

    assign merge_cnt_o = merge_cnt_q;

endmodule

// File: tb/tb_spatz_strbreq_merge_nway.sv
// Directed and randomized checks of the N-way request merger against
// a queue-based reference model of grouping, tracking and fan-out.
module tb_spatz_strbreq_merge_nway;
    import spatz_merge_pkg::*;

    localparam int NP = 8;

    logic clk = 1'b0;
    logic rst, men;
    logic [NP-1:0] v, w, oqr, opv, ipr;
    logic [NP-1:0][31:0] a, d, opd;
    logic [NP-1:0][3:0] s;
    logic [NP-1:0][4:0] idv;

    logic [NP-1:0] iqr, oqv, oqw, opr, ipv;
    logic [NP-1:0][31:0] oqa, oqd, ipd;
    logic [NP-1:0][3:0] oqs;
    logic [NP-1:0][4:0] oqi, ipi;
    logic [31:0] cnt;

    int checks = 0;
    int errors = 0;

    track_entry_t mq[NP][$];
    int unsigned mcnt;

    logic [NP-1:0] m_fol, m_oqv, m_iqr, m_ipv, m_opr;
    int m_lead[NP];
    logic [NP-1:0][3:0] m_gs;
    logic [NP-1:0][31:0] m_gd, m_ipd;
    logic [NP-1:0][NP-1:0] m_gm;
    logic [NP-1:0][NP-1:0][4:0] m_gi;
    logic [NP-1:0][4:0] m_ipi;

    always #5 clk = ~clk;

    spatz_strbreq_merge_nway dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .merge_en_i    (men),
        .in_q_valid_i  (v),
        .in_q_ready_o  (iqr),
        .in_q_addr_i   (a),
        .in_q_write_i  (w),
        .in_q_data_i   (d),
        .in_q_strb_i   (s),
        .in_q_id_i     (idv),
        .out_q_valid_o (oqv),
        .out_q_ready_i (oqr),
        .out_q_addr_o  (oqa),
        .out_q_write_o (oqw),
        .out_q_data_o  (oqd),
        .out_q_strb_o  (oqs),
        .out_q_id_o    (oqi),
        .out_p_valid_i (opv),
        .out_p_ready_o (opr),
        .out_p_data_i  (opd),
        .in_p_valid_o  (ipv),
        .in_p_ready_i  (ipr),
        .in_p_data_o   (ipd),
        .in_p_id_o     (ipi),
        .merge_cnt_o   (cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] st);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = {8{st[b]}};
        return r;
    endfunction

    task automatic clear_inputs();
        v = '0; w = '0; a = '0; d = '0; s = '0; idv = '0;
        oqr = '1; opv = '0; ipr = '1; opd = '0; men = 1'b1;
    endtask

    // Evaluate the model for the current inputs and compare the DUT.
    task automatic model_check(input string tag);
        logic [NP-1:0] pop_ok, ldr_seen;
        @(negedge clk);
        m_fol = '0;
        for (int j = 0; j < NP; j++) begin
            m_lead[j] = j;
            m_gs[j] = s[j];
            m_gd[j] = d[j];
            m_gm[j] = '0;
            m_gm[j][j] = v[j];
            m_gi[j] = '0;
            m_gi[j][j] = idv[j];
        end
        for (int j = 1; j < NP; j++) begin
            ldr_seen = '0;
            for (int i = 0; i < j; i++) begin
                if (men && ldr_seen == '0 && v[i] && v[j] && !m_fol[i] &&
                    w[i] == w[j] && (a[i] >> 2) == (a[j] >> 2)) begin
                    ldr_seen[i] = 1'b1;
                    if (!w[j] || (m_gs[i] & s[j]) == 4'h0) begin
                        m_fol[j] = 1'b1;
                        m_lead[j] = i;
                        m_gs[i] = m_gs[i] | s[j];
                        m_gd[i] = (m_gd[i] & ~bmask(s[j])) | (d[j] & bmask(s[j]));
                        m_gm[i][j] = 1'b1;
                        m_gi[i][j] = idv[j];
                    end
                end
            end
        end
        m_ipv = '0; m_opr = '0; m_ipd = '0; m_ipi = '0; pop_ok = '0;
        for (int i = 0; i < NP; i++) begin
            if (!rst && opv[i] && mq[i].size() > 0 &&
                (mq[i][0].mask & pop_ok) == '0) begin
                pop_ok |= mq[i][0].mask;
                m_ipv |= mq[i][0].mask;
                m_opr[i] = ((ipr & mq[i][0].mask) == mq[i][0].mask);
                for (int m = 0; m < NP; m++) begin
                    if (mq[i][0].mask[m]) begin
                        m_ipd[m] = opd[i];
                        m_ipi[m] = mq[i][0].ids[m];
                    end
                end
            end
        end
        for (int i = 0; i < NP; i++) begin
            m_oqv[i] = !rst && v[i] && !m_fol[i] &&
                       (mq[i].size() < 16 || m_opr[i]);
        end
        for (int m = 0; m < NP; m++) begin
            m_iqr[m] = v[m] && m_oqv[m_lead[m]] && oqr[m_lead[m]];
        end
        chk({tag, "_iqr"}, iqr, m_iqr);
        chk({tag, "_oqv"}, oqv, m_oqv);
        chk({tag, "_ipv"}, ipv, m_ipv);
        chk({tag, "_opr"}, opr, m_opr);
        chk({tag, "_cnt"}, cnt, mcnt);
        for (int i = 0; i < NP; i++) begin
            if (m_oqv[i]) begin
                chk({tag, "_addr"}, oqa[i], a[i]);
                chk({tag, "_wr"}, oqw[i], w[i]);
                chk({tag, "_id"}, oqi[i], idv[i]);
                chk({tag, "_strb"}, oqs[i], m_gs[i]);
                if (w[i]) chk({tag, "_wdata"}, oqd[i] & bmask(m_gs[i]),
                              m_gd[i] & bmask(m_gs[i]));
            end
            if (m_ipv[i]) begin
                chk({tag, "_rdata"}, ipd[i], m_ipd[i]);
                chk({tag, "_rid"}, ipi[i], m_ipi[i]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NP; i++) mq[i].delete();
            mcnt = 0;
        end else begin
            for (int i = 0; i < NP; i++) if (m_opr[i]) void'(mq[i].pop_front());
            for (int i = 0; i < NP; i++) begin
                if (m_oqv[i] && oqr[i]) begin
                    track_entry_t e;
                    e.mask = m_gm[i];
                    e.ids = m_gi[i];
                    mq[i].push_back(e);
                end
            end
            for (int m = 0; m < NP; m++)
                if (m_fol[m] && m_iqr[m] && mcnt != 32'hFFFF_FFFF) mcnt++;
        end
        #1;
    endtask

    task automatic step(input string tag);
        model_check(tag);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        mcnt = 0;
        clear_inputs();
        rst = 1'b1;
        step("rst0");
        step("rst1");
        rst = 1'b0;
        model_check("post_rst");
        chk("rst_cnt", cnt, 0);
        chk("rst_oqv", oqv, 0);
        chk("rst_ipv", ipv, 0);
        chk("rst_opr", opr, 0);
        tick();

        v = 8'h05; w = 8'h05;
        a[0] = 32'h100; a[2] = 32'h100;
        s[0] = 4'h3; s[2] = 4'hC;
        d[0] = 32'h1122_3344; d[2] = 32'hAABB_CCDD;
        model_check("s1");
        chk("s1_single", oqv, 8'h01);
        chk("s1_strbF", oqs[0], 4'hF);
        chk("s1_mux", oqd[0], 32'hAABB_3344);
        chk("s1_ready", iqr, 8'h05);
        tick();
        v = '0;
        chk("s1_merged", cnt, 1);
        opv = 8'h01;
        model_check("s1_rsp");
        chk("s1_fan", ipv, 8'h05);
        tick();
        opv = '0;

        v = 8'h0A; w = 8'h0A;
        a[1] = 32'h200; a[3] = 32'h200;
        s[1] = 4'h3; s[3] = 4'h1;
        model_check("s2");
        chk("s2_two", oqv, 8'h0A);
        chk("s2_ready", iqr, 8'h0A);
        tick();
        v = '0;
        chk("s2_nomerge", cnt, 1);
        opv = 8'h0A;
        step("s2_rsp");
        opv = '0;

        v = 8'h23; w = '0;
        a[0] = 32'h40; a[1] = 32'h40; a[5] = 32'h40;
        s = '1;
        idv[0] = 5'd3; idv[1] = 5'd7; idv[5] = 5'd9;
        model_check("s3");
        chk("s3_one", oqv, 8'h01);
        chk("s3_ready", iqr, 8'h23);
        tick();
        v = '0;
        chk("s3_cnt", cnt, 3);
        opv = 8'h01; opd[0] = 32'hDEAD_BEEF; ipr = 8'hDF;
        model_check("s3_hold");
        chk("s3_hold_rdy", opr[0], 0);
        tick();
        ipr = '1;
        model_check("s3_rsp");
        chk("s3_fan", ipv, 8'h23);
        chk("s3_id0", ipi[0], 3);
        chk("s3_id1", ipi[1], 7);
        chk("s3_id5", ipi[5], 9);
        chk("s3_data5", ipd[5], 32'hDEAD_BEEF);
        chk("s3_pop", opr[0], 1);
        tick();
        model_check("s3_empty");
        chk("s3_ignored", ipv, 0);
        chk("s3_norrdy", opr, 0);
        tick();
        opv = '0;

        men = 1'b0; v = 8'h23;
        model_check("s4");
        chk("s4_three", oqv, 8'h23);
        tick();
        v = '0;
        chk("s4_cnt", cnt, 3);
        opv = 8'h23;
        step("s4_rsp");
        opv = '0; men = 1'b1;

        v = 8'h01; w = 8'h01; a[0] = 32'h300; s[0] = 4'h1;
        for (int k = 0; k < 16; k++) begin
            d[0] = $urandom;
            idv[0] = 5'(k);
            step("s5_fill");
        end
        model_check("s5_full");
        chk("s5_stall_v", oqv[0], 0);
        chk("s5_stall_r", iqr[0], 0);
        tick();
        opv = 8'h01;
        model_check("s5_pp");
        chk("s5_pp_v", oqv[0], 1);
        chk("s5_pp_r", iqr[0], 1);
        chk("s5_pp_pop", opr[0], 1);
        tick();
        v = '0;
        for (int k = 0; k < 16; k++) step("s5_drain");
        opv = '0;

        v = 8'h0F; w = '0;
        for (int i = 0; i < 4; i++) a[i] = 32'h1000 + 32'(i) * 32'h10;
        step("s6_push");
        v = '0; rst = 1'b1;
        step("s6_rst");
        rst = 1'b0; opv = '1;
        model_check("s6_after");
        chk("s6_ipv", ipv, 0);
        chk("s6_opr", opr, 0);
        chk("s6_oqv", oqv, 0);
        chk("s6_cnt", cnt, 0);
        tick();
        opv = '0;

        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 99) == 0);
            men = ($urandom_range(0, 7) != 0);
            v = NP'($urandom);
            w = NP'($urandom);
            s = $urandom;
            oqr = NP'($urandom | $urandom);
            opv = NP'($urandom);
            ipr = NP'($urandom | $urandom);
            for (int i = 0; i < NP; i++) begin
                case ($urandom_range(0, 3))
                    0: a[i] = 32'h100;
                    1: a[i] = 32'h102;
                    2: a[i] = 32'h104;
                    default: a[i] = 32'h200;
                endcase
                d[i] = $urandom;
                opd[i] = $urandom;
                idv[i] = 5'($urandom);
            end
            step("rnd");
        end

        clear_inputs();
        rst = 1'b0;
        step("end");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
